// File: rtl/count_wrap_monitor.sv
// count_wrap_monitor: watches a 4-bit synchronous up counter, checks each
// sample for a legal advance (hold or +1 mod 16), extends the count with a
// wrap counter and reports wrap, compare-match and illegal-step events.
// All outputs come straight from registers (latency 1 from the sampled q_in).
module count_wrap_monitor #(
  parameter int HI_W  = 8,
  parameter int ERR_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          q_in,
  input  logic [HI_W+3:0]     cmp_val,
  output logic [HI_W+3:0]     ext_count,
  output logic                wrap_pulse,
  output logic                match_pulse,
  output logic                step_err,
  output logic                err_sticky,
  output logic [ERR_W-1:0]    err_cnt
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic              primed_q, primed_d;
  logic [3:0]        q_reg_q, q_reg_d;
  logic [HI_W-1:0]   hi_q, hi_d;
  logic              wrap_q, wrap_d;
  logic              match_q, match_d;
  logic              step_q, step_d;
  logic              sticky_q, sticky_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic [3:0]        q_inc;
  logic [HI_W+3:0]   ext_q, ext_d;

  assign q_inc = q_reg_q + 4'd1;
  assign ext_q = {hi_q, q_reg_q};
  assign ext_d = {hi_d, q_reg_d};

  // Classify the sampled value against the held one and form next state.
  always_comb begin
    primed_d = 1'b1;
    q_reg_d  = q_in;
    hi_d     = hi_q;
    wrap_d   = 1'b0;
    step_d   = 1'b0;
    sticky_d = sticky_q;
    err_d    = err_q;
    match_d  = 1'b0;
    if (primed_q) begin
      if (q_in == q_reg_q) begin
        // hold: nothing changes
      end else if (q_reg_q == 4'd15 && q_in == 4'd0) begin
        hi_d   = hi_q + HI_W'(1);
        wrap_d = 1'b1;
      end else if (q_in == q_inc) begin
        // normal step: q_reg_d already follows q_in
      end else begin
        step_d   = 1'b1;
        sticky_d = 1'b1;
        if (err_q != ERR_MAX) begin
          err_d = err_q + ERR_W'(1);
        end
      end
      // Match fires only on entry to cmp_val, never while sitting on it.
      match_d = (ext_d == cmp_val) && (ext_q != cmp_val);
    end
  end

  // State and output registers; reset clears all history.
  always_ff @(posedge clk) begin
    if (reset) begin
      primed_q <= 1'b0;
      q_reg_q  <= '0;
      hi_q     <= '0;
      wrap_q   <= 1'b0;
      match_q  <= 1'b0;
      step_q   <= 1'b0;
      sticky_q <= 1'b0;
      err_q    <= '0;
    end else begin
      primed_q <= primed_d;
      q_reg_q  <= q_reg_d;
      hi_q     <= hi_d;
      wrap_q   <= wrap_d;
      match_q  <= match_d;
      step_q   <= step_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
    end
  end

  assign ext_count   = ext_q;
  assign wrap_pulse  = wrap_q;
  assign match_pulse = match_q;
  assign step_err    = step_q;
  assign err_sticky  = sticky_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Testbench for count_wrap_monitor: directed scenarios plus a random run,
// all checked against an arithmetic model of the extended count.
module tb_count_wrap_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  q_in;
  logic [11:0] cmp_val;
  logic [11:0] ext_count;
  logic        wrap_pulse, match_pulse, step_err, err_sticky;
  logic [3:0]  err_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  // model state: extended count as a plain integer
  int m_ext;
  bit m_primed;
  int m_err;
  bit m_sticky;
  bit m_wrap, m_step, m_match;

  int n_wrap_seen, n_match_seen;

  count_wrap_monitor #(.HI_W(8), .ERR_W(4)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .cmp_val(cmp_val),
    .ext_count(ext_count), .wrap_pulse(wrap_pulse), .match_pulse(match_pulse),
    .step_err(step_err), .err_sticky(err_sticky), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".ext"},    32'(ext_count),   32'(m_ext));
    chk({tag, ".wrap"},   32'(wrap_pulse),  32'(m_wrap));
    chk({tag, ".match"},  32'(match_pulse), 32'(m_match));
    chk({tag, ".step"},   32'(step_err),    32'(m_step));
    chk({tag, ".sticky"}, 32'(err_sticky),  32'(m_sticky));
    chk({tag, ".errcnt"}, 32'(err_cnt),     32'(m_err));
  endtask

  task automatic rst(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      m_ext = 0; m_primed = 0; m_err = 0; m_sticky = 0;
      m_wrap = 0; m_step = 0; m_match = 0;
      chk_all("reset");
    end
    reset = 1'b0;
  endtask

  // One clock with the given inputs; model advances by the counting rules.
  task automatic cyc(input logic [3:0] q, input logic [11:0] c, input string tag);
    int prev, d;
    q_in = q; cmp_val = c;
    @(posedge clk);
    prev = m_ext;
    m_wrap = 0; m_step = 0; m_match = 0;
    if (!m_primed) begin
      m_ext = (m_ext / 16) * 16 + int'(q);
      m_primed = 1;
    end else begin
      d = (int'(q) - (m_ext % 16) + 16) % 16;
      if (d == 1) begin
        if (m_ext % 16 == 15) m_wrap = 1;
        m_ext = (m_ext + 1) % 4096;
      end else if (d != 0) begin
        m_step = 1; m_sticky = 1;
        if (m_err < 15) m_err++;
        m_ext = (m_ext / 16) * 16 + int'(q);
      end
      m_match = (m_ext == int'(c)) && (prev != int'(c));
    end
    #1;
    chk_all(tag);
    n_wrap_seen  += int'(wrap_pulse);
    n_match_seen += int'(match_pulse);
  endtask

  initial begin
    reset = 1'b1; q_in = '0; cmp_val = 12'hFFF;
    m_ext = 0; m_primed = 0; m_err = 0; m_sticky = 0;
    m_wrap = 0; m_step = 0; m_match = 0;

    // 1: count 0..15,0,1 with one wrap
    rst(2);
    for (int i = 0; i < 18; i++) cyc(4'(i % 16), 12'hFFF, "t1");
    chk("t1.final_ext", 32'(ext_count), 32'h011);

    // 2: three wraps with a compare point at 0x025
    rst(1);
    n_wrap_seen = 0; n_match_seen = 0;
    for (int i = 0; i <= 48; i++) cyc(4'(i % 16), 12'h025, "t2");
    chk("t2.wraps", 32'(n_wrap_seen), 32'd3);
    chk("t2.matches", 32'(n_match_seen), 32'd1);
    chk("t2.errcnt", 32'(err_cnt), 32'd0);

    // 3: holds are legal
    rst(1);
    cyc(4'd3, 12'hFFF, "t3"); cyc(4'd4, 12'hFFF, "t3"); cyc(4'd4, 12'hFFF, "t3");
    cyc(4'd4, 12'hFFF, "t3"); cyc(4'd5, 12'hFFF, "t3");
    chk("t3.ext", 32'(ext_count), 32'h005);

    // 4: one illegal jump then resync
    cyc(4'd5, 12'hFFF, "t4"); cyc(4'd6, 12'hFFF, "t4"); cyc(4'd9, 12'hFFF, "t4");
    chk("t4.step_err", 32'(step_err), 32'd1);
    cyc(4'd10, 12'hFFF, "t4");
    chk("t4.step_after", 32'(step_err), 32'd0);
    chk("t4.errcnt", 32'(err_cnt), 32'd1);

    // 5: error counter saturation; illegal step landing on cmp_val
    for (int i = 0; i < 20; i++) cyc(4'((10 + 8 * (i + 1)) % 16), 12'h002, "t5");
    chk("t5.errcnt_sat", 32'(err_cnt), 32'd15);
    chk("t5.sticky", 32'(err_sticky), 32'd1);

    // 6: reset mid-count at 0x137
    rst(1);
    for (int i = 0; i <= 311; i++) cyc(4'(i % 16), 12'hFFF, "t6");
    chk("t6.pre_ext", 32'(ext_count), 32'h137);
    rst(1);
    cyc(4'd7, 12'h007, "t6.post");
    chk("t6.first_step", 32'(step_err), 32'd0);
    cyc(4'd8, 12'h008, "t6.post");
    chk("t6.second_ext", 32'(ext_count), 32'h008);

    // wrap that lands on cmp_val: both pulses together
    rst(1);
    for (int i = 0; i <= 16; i++) cyc(4'(i % 16), 12'h010, "wm");
    chk("wm.wrap", 32'(wrap_pulse), 32'd1);
    chk("wm.match", 32'(match_pulse), 32'd1);

    // random run
    rst(1);
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [3:0] qn;
      logic [11:0] cn;
      r = int'($urandom_range(0, 9));
      if (r < 6)      qn = 4'((m_ext + 1) % 16);
      else if (r < 8) qn = 4'(m_ext % 16);
      else            qn = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) cn = 12'($urandom_range(0, 4095));
      else cn = 12'((m_ext + int'($urandom_range(0, 2))) % 4096);
      if ($urandom_range(0, 99) == 0) rst(1);
      cyc(qn, cn, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
